collision_scan_sched: RTL and testbench
=======================================

// Module: collision_scan_sched
// PURPOSE
//  Time-multiplexes one registered collision unit (blue 47x41 sprite vs one 25x24 ground tile)
//  across a tile table of up to N_TILES entries, once per frame. Reads tile coordinates from a
//  synchronous tile ROM and drives them into the collision unit. ORs the returned 4-bit side
//  flags (0=down, 1=up, 2=right, 3=left) into one per-frame contact vector for the movement logic.
// PARAMETERS
//  N_TILES  32  tile table entries scanned per frame (1..2**ADDR_W)
//  ADDR_W   5   tile ROM address width
// PORTS
//  clk            in   1       system clock
//  rst_n          in   1       reset, asynchronous, active-low
//  frame_start    in   1       1-cycle pulse: begin scan; sampled only in IDLE
//  x_blue         in   10      blue sprite x; captured on accepted frame_start
//  y_blue         in   9       blue sprite y; captured on accepted frame_start
//  tile_addr      out  ADDR_W  tile ROM address
//  tile_x         in   10      ROM data x, valid the cycle after tile_addr (1-cycle latency)
//  tile_y         in   9       ROM data y, same timing as tile_x
//  coll_x_blue    out  10      to collision unit: captured x_blue, held for whole scan
//  coll_y_blue    out  9       to collision unit: captured y_blue
//  coll_x_ground  out  10      to collision unit: tile x (registered)
//  coll_y_ground  out  9       to collision unit: tile y (registered)
//  coll_flags     in   4       from collision unit; registered, 1-cycle latency after coll_*_ground
//  busy           out  1       high from cycle after accepted frame_start until contact_valid
//  contact        out  4       OR of coll_flags over all valid tiles of last completed scan
//  contact_valid  out  1       1-cycle pulse: contact updated
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, pipeline valid bits cleared; reset mid-scan aborts
//    immediately, no contact_valid, contact returns to 0.
//  - FSM: IDLE -(frame_start)-> ISSUE -(last addr issued or sentinel seen)-> DRAIN
//    -(pipeline empty)-> DONE (1 cycle, contact_valid=1) -> IDLE.
//  - Pipeline (cycle 0 = frame_start accepted in IDLE): addr i driven in cycle 1+i; tile data i
//    in cycle 2+i; coll_*_ground = tile i in cycle 3+i; coll_flags for tile i in cycle 4+i,
//    ORed into accumulator at end of that cycle. Each stage carries a valid bit.
//  - Full scan: contact/contact_valid/busy-fall visible in cycle N_TILES+4.
//  - Sentinel: tile_x==10'h3FF at index k ends list; tile k and any later address already
//    issued are invalidated (flags ignored); result as if N_TILES=k: contact_valid in cycle k+4.
//    k=0 -> contact=0, contact_valid in cycle 4.
//  - Accumulator cleared on frame_start acceptance; contact register updated only in DONE,
//    held between scans. No partial results ever visible on contact.
//  - frame_start while busy or in DONE: ignored, no queueing.
//  - tile_addr counter ADDR_W bits; stops at N_TILES-1, never wraps within a scan.
//  - No arithmetic on coordinates in this block; widths pass through unchanged.
//  - coll_*_blue hold captured values after scan until next accepted frame_start.
// CONFIGURATION
//  - COLL_HIT_INDEX_EN defined: adds outputs hit_any (1) and hit_idx (ADDR_W): lowest valid tile
//    index whose coll_flags[0] (down) was set this scan; updated with contact in DONE; reset 0;
//    hit_any=0 -> hit_idx=0.
//  - Undefined: ports and logic absent; all other behaviour identical.
// TESTING
//  - N_TILES=4, flags model returns 0 for all tiles -> contact=4'b0000, contact_valid in cycle 8.
//  - Tile 2 returns 4'b0001, tile 3 returns 4'b0100 -> contact=4'b0101; hit_idx=2 with _EN.
//  - Tile 1 has tile_x=10'h3FF, tile 2 would return 4'b1111 -> contact=0, valid in cycle 5.
//  - frame_start re-pulsed at cycles 2 and 8 of a 4-tile scan -> ignored, exactly one valid pulse.
//  - rst_n low in cycle 5 of scan -> outputs 0 at once, no contact_valid; new scan then works.
//  - Two back-to-back scans, x_blue changed mid-scan -> coll_x_blue stays at captured value.

Source files
------------

// File: rtl/collision_scan_sched.sv
// collision_scan_sched: walks the tile table once per frame through one shared collision unit and
// ORs the per-tile side flags into a frame contact vector. Optional feature macro: COLL_HIT_INDEX_EN.
module collision_scan_sched #(
    parameter int N_TILES = 32,
    parameter int ADDR_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_start,
    input  logic [9:0]        x_blue,
    input  logic [8:0]        y_blue,
    output logic [ADDR_W-1:0] tile_addr,
    input  logic [9:0]        tile_x,
    input  logic [8:0]        tile_y,
    output logic [9:0]        coll_x_blue,
    output logic [8:0]        coll_y_blue,
    output logic [9:0]        coll_x_ground,
    output logic [8:0]        coll_y_ground,
    input  logic [3:0]        coll_flags,
    output logic              busy,
    output logic [3:0]        contact,
    output logic              contact_valid
`ifdef COLL_HIT_INDEX_EN
    ,
    output logic              hit_any,
    output logic [ADDR_W-1:0] hit_idx
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(N_TILES - 1);
    localparam logic [9:0]        SENTINEL_X = 10'h3FF;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   tile_addr_q, tile_addr_d;
    logic [9:0]          x_blue_q, x_blue_d;
    logic [8:0]          y_blue_q, y_blue_d;
    logic [9:0]          gnd_x_q, gnd_x_d;
    logic [8:0]          gnd_y_q, gnd_y_d;
    logic                vld_p1_q, vld_p1_d;
    logic                vld_p2_q, vld_p2_d;
    logic                vld_p3_q, vld_p3_d;
    logic [3:0]          acc_q, acc_d;
    logic [3:0]          contact_q, contact_d;
    logic                accept;
    logic                sentinel;
    logic [3:0]          flags_in;
`ifdef COLL_HIT_INDEX_EN
    logic [ADDR_W-1:0]   flag_idx_q, flag_idx_d;
    logic                acc_hit_q, acc_hit_d;
    logic [ADDR_W-1:0]   acc_idx_q, acc_idx_d;
    logic                hit_any_q, hit_any_d;
    logic [ADDR_W-1:0]   hit_idx_q, hit_idx_d;
`endif

    always_comb begin
        state_d     = state_q;
        tile_addr_d = tile_addr_q;
        x_blue_d    = x_blue_q;
        y_blue_d    = y_blue_q;
        gnd_x_d     = gnd_x_q;
        gnd_y_d     = gnd_y_q;
        contact_d   = contact_q;
`ifdef COLL_HIT_INDEX_EN
        flag_idx_d  = flag_idx_q;
        acc_hit_d   = acc_hit_q;
        acc_idx_d   = acc_idx_q;
        hit_any_d   = hit_any_q;
        hit_idx_d   = hit_idx_q;
`endif

        accept   = (state_q == S_IDLE) && frame_start;
        // A sentinel kills its own tile and the address issued in the same cycle.
        sentinel = vld_p1_q && (tile_x == SENTINEL_X);
        flags_in = vld_p3_q ? coll_flags : 4'b0000;

        vld_p1_d = (state_q == S_ISSUE) && !sentinel;
        vld_p2_d = vld_p1_q && !sentinel;
        vld_p3_d = vld_p2_q;
        acc_d    = acc_q | flags_in;

        if (vld_p1_q) begin
            gnd_x_d = tile_x;
            gnd_y_d = tile_y;
        end

`ifdef COLL_HIT_INDEX_EN
        // Tiles reach the flag stage in table order, so a running count is the tile index.
        if (vld_p3_q) begin
            flag_idx_d = flag_idx_q + 1'b1;
            if (coll_flags[0] && !acc_hit_q) begin
                acc_hit_d = 1'b1;
                acc_idx_d = flag_idx_q;
            end
        end
`endif

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d     = S_ISSUE;
                    tile_addr_d = '0;
                    x_blue_d    = x_blue;
                    y_blue_d    = y_blue;
                    acc_d       = 4'b0000;
`ifdef COLL_HIT_INDEX_EN
                    flag_idx_d  = '0;
                    acc_hit_d   = 1'b0;
                    acc_idx_d   = '0;
`endif
                end
            end
            S_ISSUE: begin
                if (sentinel || (tile_addr_q == LAST_ADDR)) begin
                    state_d = S_DRAIN;
                end else begin
                    tile_addr_d = tile_addr_q + 1'b1;
                end
            end
            S_DRAIN: begin
                // The flag stage may still hold a tile; it is folded in on the way to DONE.
                if (!vld_p1_q && !vld_p2_q) begin
                    state_d   = S_DONE;
                    contact_d = acc_q | flags_in;
`ifdef COLL_HIT_INDEX_EN
                    if (acc_hit_q) begin
                        hit_any_d = 1'b1;
                        hit_idx_d = acc_idx_q;
                    end else if (vld_p3_q && coll_flags[0]) begin
                        hit_any_d = 1'b1;
                        hit_idx_d = flag_idx_q;
                    end else begin
                        hit_any_d = 1'b0;
                        hit_idx_d = '0;
                    end
`endif
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            tile_addr_q <= '0;
            x_blue_q    <= '0;
            y_blue_q    <= '0;
            gnd_x_q     <= '0;
            gnd_y_q     <= '0;
            vld_p1_q    <= 1'b0;
            vld_p2_q    <= 1'b0;
            vld_p3_q    <= 1'b0;
            acc_q       <= '0;
            contact_q   <= '0;
`ifdef COLL_HIT_INDEX_EN
            flag_idx_q  <= '0;
            acc_hit_q   <= 1'b0;
            acc_idx_q   <= '0;
            hit_any_q   <= 1'b0;
            hit_idx_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            tile_addr_q <= tile_addr_d;
            x_blue_q    <= x_blue_d;
            y_blue_q    <= y_blue_d;
            gnd_x_q     <= gnd_x_d;
            gnd_y_q     <= gnd_y_d;
            vld_p1_q    <= vld_p1_d;
            vld_p2_q    <= vld_p2_d;
            vld_p3_q    <= vld_p3_d;
            acc_q       <= acc_d;
            contact_q   <= contact_d;
`ifdef COLL_HIT_INDEX_EN
            flag_idx_q  <= flag_idx_d;
            acc_hit_q   <= acc_hit_d;
            acc_idx_q   <= acc_idx_d;
            hit_any_q   <= hit_any_d;
            hit_idx_q   <= hit_idx_d;
`endif
        end
    end

    assign tile_addr     = tile_addr_q;
    assign coll_x_blue   = x_blue_q;
    assign coll_y_blue   = y_blue_q;
    assign coll_x_ground = gnd_x_q;
    assign coll_y_ground = gnd_y_q;
    assign busy          = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    assign contact       = contact_q;
    assign contact_valid = (state_q == S_DONE);
`ifdef COLL_HIT_INDEX_EN
    assign hit_any       = hit_any_q;
    assign hit_idx       = hit_idx_q;
`endif

endmodule

// File: tb/tb_collision_scan_sched.sv
// Bench for collision_scan_sched: ROM and collision-unit stand-ins, a per-scan behavioural model
// and a per-cycle compare process, plus directed scenarios with hand-computed expectations.
module tb_collision_scan_sched;

    localparam int N      = 4;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              frame_start;
    logic [9:0]        x_blue;
    logic [8:0]        y_blue;
    logic [ADDR_W-1:0] tile_addr;
    logic [9:0]        tile_x = '0;
    logic [8:0]        tile_y = '0;
    logic [9:0]        coll_x_blue;
    logic [8:0]        coll_y_blue;
    logic [9:0]        coll_x_ground;
    logic [8:0]        coll_y_ground;
    logic [3:0]        coll_flags = '0;
    logic              busy;
    logic [3:0]        contact;
    logic              contact_valid;
`ifdef COLL_HIT_INDEX_EN
    logic              hit_any;
    logic [ADDR_W-1:0] hit_idx;
`endif

    collision_scan_sched #(.N_TILES(N), .ADDR_W(ADDR_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .frame_start   (frame_start),
        .x_blue        (x_blue),
        .y_blue        (y_blue),
        .tile_addr     (tile_addr),
        .tile_x        (tile_x),
        .tile_y        (tile_y),
        .coll_x_blue   (coll_x_blue),
        .coll_y_blue   (coll_y_blue),
        .coll_x_ground (coll_x_ground),
        .coll_y_ground (coll_y_ground),
        .coll_flags    (coll_flags),
        .busy          (busy),
        .contact       (contact),
        .contact_valid (contact_valid)
`ifdef COLL_HIT_INDEX_EN
        ,
        .hit_any       (hit_any),
        .hit_idx       (hit_idx)
`endif
    );

    always #5 clk = ~clk;

    logic [9:0] rom_x    [32];
    logic [8:0] rom_y    [32];
    logic [3:0] flag_tab [32];

    int errs   = 0;
    int nchk   = 0;
    int cyc    = 0;
    int vcount = 0;

    // Model state: one scan at a time, described by its start cycle and effective length.
    bit         m_active  = 1'b0;
    int         m_start   = 0;
    int         m_k       = 0;
    logic [3:0] m_res     = '0;
    logic [3:0] m_contact = '0;
    logic [9:0] m_xb      = '0;
    logic [8:0] m_yb      = '0;
    bit         m_rany    = 1'b0;
    int         m_ridx    = 0;
    bit         mh_any    = 1'b0;
    int         mh_idx    = 0;

    function automatic logic [3:0] coll_model(input logic [9:0] gx);
        logic [3:0] f;
        f = 4'b0000;
        for (int j = 0; j < 32; j++) begin
            if (rom_x[j] == gx) f = flag_tab[j];
        end
        return f;
    endfunction

    always @(posedge clk) begin
        tile_x     <= rom_x[tile_addr];
        tile_y     <= rom_y[tile_addr];
        coll_flags <= coll_model(coll_x_ground);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_tables();
        for (int i = 0; i < 32; i++) begin
            rom_x[i]    = 10'(i * 20 + 3);
            rom_y[i]    = 9'(i * 5 + 2);
            flag_tab[i] = (i >= N) ? 4'b1000 : 4'b0000;
        end
    endtask

    task automatic predict();
        bit stop;
        stop   = 1'b0;
        m_k    = N;
        m_res  = 4'b0000;
        m_rany = 1'b0;
        m_ridx = 0;
        for (int i = 0; i < N; i++) begin
            if (!stop) begin
                if (rom_x[i] == 10'h3FF) begin
                    stop = 1'b1;
                    m_k  = i;
                end else begin
                    m_res = m_res | flag_tab[i];
                    if (flag_tab[i][0] && !m_rany) begin
                        m_rany = 1'b1;
                        m_ridx = i;
                    end
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_active  = 1'b0;
                m_contact = 4'b0000;
                m_xb      = '0;
                m_yb      = '0;
                mh_any    = 1'b0;
                mh_idx    = 0;
            end else begin
                if (m_active) begin
                    if (cyc - m_start == m_k + 3) begin
                        m_contact = m_res;
                        mh_any    = m_rany;
                        mh_idx    = m_ridx;
                    end
                    if (cyc - m_start == m_k + 4) m_active = 1'b0;
                end else if (frame_start) begin
                    m_active = 1'b1;
                    m_start  = cyc;
                    m_xb     = x_blue;
                    m_yb     = y_blue;
                    predict();
                end
                cyc++;
            end
        end
    end

    initial begin
        int rel;
        int lim;
        forever begin
            @(negedge clk);
            if (contact_valid) vcount++;
            if (!rst_n) begin
                check("rst_busy", 32'(busy), 32'd0);
                check("rst_valid", 32'(contact_valid), 32'd0);
                check("rst_contact", 32'(contact), 32'd0);
                check("rst_xblue", 32'(coll_x_blue), 32'd0);
                check("rst_addr", 32'(tile_addr), 32'd0);
            end else begin
                rel = m_active ? (cyc - m_start) : -1;
                lim = (m_k + 2 < N) ? (m_k + 2) : N;
                check("busy", 32'(busy), 32'(m_active && rel >= 1 && rel <= m_k + 3));
                check("contact_valid", 32'(contact_valid), 32'(m_active && rel == m_k + 4));
                check("contact", 32'(contact), 32'(m_contact));
                check("coll_x_blue", 32'(coll_x_blue), 32'(m_xb));
                check("coll_y_blue", 32'(coll_y_blue), 32'(m_yb));
`ifdef COLL_HIT_INDEX_EN
                check("hit_any", 32'(hit_any), 32'(mh_any));
                check("hit_idx", 32'(hit_idx), 32'(mh_idx));
`endif
                if (m_active && rel >= 1 && rel <= lim)
                    check("tile_addr", 32'(tile_addr), 32'(rel - 1));
                if (m_active && rel >= 3 && rel <= m_k + 2) begin
                    check("coll_x_ground", 32'(coll_x_ground), 32'(rom_x[rel - 3]));
                    check("coll_y_ground", 32'(coll_y_ground), 32'(rom_y[rel - 3]));
                end
            end
        end
    end

    task automatic start_scan(input logic [9:0] x, input logic [8:0] y);
        @(posedge clk);
        #1;
        x_blue      = x;
        y_blue      = y;
        frame_start = 1'b1;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
    endtask

    task automatic wait_done(input int rel0, output int rel, output logic [3:0] c);
        int n;
        bit seen;
        n    = rel0;
        seen = 1'b0;
        rel  = -1;
        c    = 4'h0;
        while (!seen && n < 40) begin
            @(negedge clk);
            if (contact_valid) begin
                seen = 1'b1;
                rel  = n;
                c    = contact;
            end else begin
                n++;
            end
        end
        if (!seen) begin
            nchk++;
            errs++;
            $display("FAIL wait_done: no contact_valid within %0d cycles", 40);
        end
    endtask

    initial begin
        int rel;
        int vc0;
        logic [3:0] c;
        rst_n       = 1'b0;
        frame_start = 1'b0;
        x_blue      = '0;
        y_blue      = '0;
        set_tables();
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_contact", 32'(contact), 32'd0);
        check("reset_valid", 32'(contact_valid), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // All-zero flags over four tiles.
        start_scan(10'd40, 9'd30);
        wait_done(1, rel, c);
        check("zero_rel", 32'(rel), 32'd8);
        check("zero_contact", 32'(c), 32'h0);

        // Tile 2 down, tile 3 right.
        flag_tab[2] = 4'b0001;
        flag_tab[3] = 4'b0100;
        start_scan(10'd41, 9'd31);
        wait_done(1, rel, c);
        check("or_rel", 32'(rel), 32'd8);
        check("or_contact", 32'(c), 32'h5);
`ifdef COLL_HIT_INDEX_EN
        check("or_hit_any", 32'(hit_any), 32'd1);
        check("or_hit_idx", 32'(hit_idx), 32'd2);
`endif

        // Sentinel at tile 1 hides tile 2's full flags.
        set_tables();
        rom_x[1]    = 10'h3FF;
        flag_tab[1] = 4'b0010;
        flag_tab[2] = 4'b1111;
        start_scan(10'd42, 9'd32);
        wait_done(1, rel, c);
        check("sent1_rel", 32'(rel), 32'd5);
        check("sent1_contact", 32'(c), 32'h0);

        // Re-pulses during the scan and in DONE are dropped.
        set_tables();
        flag_tab[0] = 4'b0010;
        vc0 = vcount;
        start_scan(10'd43, 9'd33);
        @(posedge clk);
        #1 frame_start = 1'b1;
        @(posedge clk);
        #1 frame_start = 1'b0;
        repeat (5) @(posedge clk);
        #1 frame_start = 1'b1;
        @(posedge clk);
        #1 frame_start = 1'b0;
        repeat (6) @(posedge clk);
        check("repulse_pulses", 32'(vcount - vc0), 32'd1);
        check("repulse_contact", 32'(contact), 32'h2);

        // Sentinel at tile 0: empty list.
        set_tables();
        rom_x[0]    = 10'h3FF;
        flag_tab[0] = 4'b1111;
        start_scan(10'd44, 9'd34);
        wait_done(1, rel, c);
        check("sent0_rel", 32'(rel), 32'd4);
        check("sent0_contact", 32'(c), 32'h0);

        // Asynchronous reset in cycle 5 of a scan.
        set_tables();
        flag_tab[1] = 4'b0110;
        start_scan(10'd45, 9'd35);
        wait_done(1, rel, c);
        check("pre_rst_contact", 32'(c), 32'h6);
        vc0 = vcount;
        start_scan(10'd46, 9'd36);
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_contact", 32'(contact), 32'h0);
        check("abort_xblue", 32'(coll_x_blue), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        check("abort_pulses", 32'(vcount - vc0), 32'd0);
        start_scan(10'd47, 9'd37);
        wait_done(1, rel, c);
        check("post_rst_rel", 32'(rel), 32'd8);
        check("post_rst_contact", 32'(c), 32'h6);

        // Back-to-back scans with x_blue moving mid-scan.
        set_tables();
        flag_tab[0] = 4'b0100;
        start_scan(10'd100, 9'd50);
        repeat (2) @(posedge clk);
        #1;
        x_blue = 10'd555;
        y_blue = 9'd77;
        check("b2b_hold_x", 32'(coll_x_blue), 32'd100);
        wait_done(3, rel, c);
        check("b2b_contact", 32'(c), 32'h4);
        start_scan(10'd555, 9'd77);
        @(negedge clk);
        check("b2b_new_x", 32'(coll_x_blue), 32'd555);
        wait_done(2, rel, c);
        check("b2b_rel", 32'(rel), 32'd8);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end

endmodule
